// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : State encoding and counter sizing shared by the debouncer.
// Revision : 1.0
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_e;

  // Counter must hold STABLE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : debounce_edge
// Purpose  : Debounced level of a synchronized input, rise/fall pulses and a
//            wrapping rise-event counter.
// Revision : 1.0
// ============================================================================
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int EVT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_sync,
  input  logic                 evt_clr,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [EVT_WIDTH-1:0] rise_count
);

  localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [EVT_WIDTH-1:0] rise_count_q, rise_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOW;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      rise_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      rise_count_q <= rise_count_d;
    end
  end

  // Count starts at 1 on leaving a settled state: that sample is the first
  // of the qualification window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOW: begin
        if (in_sync) begin
          state_d = S_RISE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      S_RISE_WAIT: begin
        if (!in_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!in_sync) begin
          state_d = S_FALL_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      S_FALL_WAIT: begin
        if (in_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (state_q == S_RISE_WAIT && state_d == S_HIGH) begin
      level_d = 1'b1;
      rise_d  = 1'b1;
    end
    if (state_q == S_FALL_WAIT && state_d == S_LOW) begin
      level_d = 1'b0;
      fall_d  = 1'b1;
    end
    // Clear takes effect first so a coincident rise lands on 1.
    rise_count_d = evt_clr ? '0 : rise_count_q;
    if (rise_d) begin
      rise_count_d = rise_count_d + EVT_WIDTH'(1);
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign rise_count = rise_count_q;

endmodule
`default_nettype wire

// File: doc/debounce_edge.md
# debounce_edge

Debounces a single already-synchronized input bit and turns it into a clean level plus one-cycle rise/fall event pulses. It sits directly downstream of the multi-flop input synchronizer and consumes that stage's output. A wrapping rise-event counter feeds status logic (button-press counts, switch activity).

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical samples required before `level` changes; legal range 2..65535.
- `EVT_WIDTH`, default 8: width of `rise_count`.
- `clk`  in  1  system clock; all sampling on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `in_sync`  in  1  synchronized raw input from the upstream synchronizer; treated as glitch-prone but metastability-free.
- `evt_clr`  in  1  synchronous clear of `rise_count`.
- `level`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle pulse when `level` goes 0→1, registered.
- `fall`  out  1  one-cycle pulse when `level` goes 1→0, registered.
- `rise_count`  out  `EVT_WIDTH`  number of rise events since reset/clear, wraps modulo 2^`EVT_WIDTH`.

## Operation
- Four-state FSM: `S_LOW`, `S_RISE_WAIT`, `S_HIGH`, `S_FALL_WAIT`; internal counter `cnt`, width `$clog2(STABLE_CYCLES)`.
- `S_LOW`: `in_sync`=1 → `S_RISE_WAIT`, `cnt`←1; else stay, `cnt`←0.
- `S_RISE_WAIT`: `in_sync`=0 → `S_LOW`, `cnt`←0 (bounce rejected, no pulse). `in_sync`=1 and `cnt`==`STABLE_CYCLES`-1 → `S_HIGH`, `level`←1, `rise`←1, `cnt`←0. Otherwise `cnt`←`cnt`+1.
- `S_HIGH` / `S_FALL_WAIT`: mirror image with `in_sync` inverted; the transition into `S_LOW` sets `level`←0 and `fall`←1.
- `rise`/`fall` are 0 on every cycle except the single transition cycle; never both 1.
- `rise_count`: `evt_clr`=1 → 0, unless a rise occurs the same cycle → 1 (the clear applies first, then the increment). Otherwise increments on each rise; the value after all-ones is 0.
- Reset: state `S_LOW`, `cnt`=0, `level`=0, `rise`=0, `fall`=0, `rise_count`=0. There is no implicit rise after reset even if `in_sync`=1; it must be held for `STABLE_CYCLES` samples first.
- Reset mid-wait discards the partial count; there is no pulse on reset release.

## Timing
- `in_sync` sampled 1 on N=`STABLE_CYCLES` consecutive rising edges (previously `level`=0): `level` and `rise` are 1 after the Nth of those edges. `rise` drops after the next edge.
- A single opposite sample anywhere in the window restarts qualification from the next differing sample.
- Minimum spacing between `rise` and the following `fall` is N cycles.
- `rise_count` updates on the same edge that sets `rise`.
- All outputs come directly from flops; there is no combinational path from input to output.

## Structure
- `debounce_pkg`: state enum encoding (2-bit) and a `cnt_width` helper function.
- No sub-module needed; FSM, counter and event counter are inline in one module.

## Test plan
- `STABLE_CYCLES`=4, reset, `in_sync`=1 held → `level`=1 and `rise`=1 exactly 4 edges after the first high sample. `rise` is high for 1 cycle; `rise_count`=1.
- `in_sync` pattern 1,1,1,0,1,1,1,1 from `level`=0 → no pulse during the first three 1s; `rise` fires after the 4th 1 of the final run; `rise_count`=1.
- From `level`=1, `in_sync`=0 for 4 cycles → `fall` for 1 cycle and `level`=0; `rise_count` unchanged.
- `EVT_WIDTH`=2, drive 5 clean rises → `rise_count` sequence 1,2,3,0,1.
- `evt_clr`=1 on the same cycle as a rise with `rise_count`=2 → `rise_count`=1. `evt_clr` alone → 0.
- Assert `rst_n`=0 midway through `S_RISE_WAIT` (`cnt`=2), release with `in_sync`=1 → all outputs 0 during reset; `rise` only after 4 further high samples.
